// File: rtl/fp_mult_assemble_pkg.sv
// Shared constants and types for the FP multiplier back end (normalise, round, pack).
package fp_mult_assemble_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int DWIDTH = 1 + EXP_W + MAN_W;
    localparam int MP_W   = 2*MAN_W + 2;
    // Working exponent: two extra bits hold sums above the field and negative values.
    localparam int ES_W   = EXP_W + 2;

    localparam logic signed [ES_W-1:0] E_MAX  = ES_W'(2**EXP_W - 1);
    localparam logic signed [ES_W-1:0] E_ZERO = '0;
    localparam logic [EXP_W-1:0]       EXP_ONES = '1;
    localparam logic [DWIDTH-1:0]      QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // InputExc bit positions
    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    // flags bit positions
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Operand class, decided once from the exception vector and carried down the pipe.
    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_INVALID
    } exc_cls_t;

    typedef struct packed {
        logic                   s;
        logic signed [ES_W-1:0] e;
        logic [MAN_W-1:0]       man;
        logic                   guard;
        logic                   sticky;
        exc_cls_t               cls;
    } s1_t;

    typedef struct packed {
        logic                   s;
        logic signed [ES_W-1:0] e;
        logic [MAN_W-1:0]       man;
        logic                   inexact;
        exc_cls_t               cls;
    } s2_t;

endpackage

// File: rtl/fp_mult_assemble_round.sv
// Round-to-nearest-even on a truncated mantissa; carry signals mantissa wrap.
module fp_round_rne
    import fp_mult_assemble_pkg::*;
#(
    parameter int W = MAN_W
) (
    input  logic [W-1:0] man,
    input  logic         guard,
    input  logic         sticky,
    output logic [W-1:0] man_rnd,
    output logic         carry,
    output logic         inexact
);

    logic round_up;

    // Ties (guard set, sticky clear) round toward an even lsb.
    assign round_up           = guard & (sticky | man[0]);
    assign {carry, man_rnd}   = {1'b0, man} + (W+1)'(round_up);
    assign inexact            = guard | sticky;

endmodule

// File: rtl/fp_mult_assemble.sv
// FP multiplier back end: 3-stage valid/ready pipe (normalise, round, exception/pack).
module fp_mult_assemble
    import fp_mult_assemble_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                Sa,
    input  logic                Sb,
    input  logic [EXP_W-1:0]    Ea,
    input  logic [EXP_W-1:0]    Eb,
    input  logic [MP_W-1:0]     Mp,
    input  logic [4:0]          InputExc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   result,
    output logic [3:0]          flags
);

    logic v1, v2, v3;
    logic load1, load2, load3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [DWIDTH-1:0] res_d;
    logic [3:0]        flg_d;

    logic [MP_W-2:0] mp_n;
    logic nan_in, inf_zero, any_inf, any_zero;
    logic [MAN_W-1:0] man_rnd;
    logic rnd_carry, rnd_inexact;
    logic signed [ES_W-1:0] e3;

    // The summary "any" bit is redundant with the individual bits and is not consumed.
    logic unused_exc_any;
    assign unused_exc_any = InputExc[EXC_ANY];

    // A stage can load when it is empty or its contents move on this cycle.
    assign load3     = ~v3 | out_ready;
    assign load2     = ~v2 | load3;
    assign load1     = ~v1 | load2;
    assign in_ready  = load1;
    assign out_valid = v3;

    // S1: sign, unbiased-sum exponent, normalise product, extract guard/sticky, classify.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_d     = '0;
        mp_n     = Mp[MP_W-1] ? Mp[MP_W-2:0] : {Mp[MP_W-3:0], 1'b0};
        nan_in   = InputExc[EXC_ANAN] | InputExc[EXC_BNAN];
        inf_zero = (InputExc[EXC_AINF] & (Eb == '0)) | (InputExc[EXC_BINF] & (Ea == '0));
        any_inf  = InputExc[EXC_AINF] | InputExc[EXC_BINF];
        any_zero = (Ea == '0) | (Eb == '0);

        s1_d.s      = Sa ^ Sb;
        s1_d.e      = ES_W'(Ea) + ES_W'(Eb) - ES_W'(BIAS) + ES_W'(Mp[MP_W-1]);
        s1_d.man    = mp_n[MP_W-2 -: MAN_W];
        s1_d.guard  = mp_n[MP_W-2-MAN_W];
        s1_d.sticky = |mp_n[MP_W-3-MAN_W:0];

        if (inf_zero)      s1_d.cls = CLS_INVALID;
        else if (nan_in)   s1_d.cls = CLS_NAN;
        else if (any_inf)  s1_d.cls = CLS_INF;
        else if (any_zero) s1_d.cls = CLS_ZERO;
        else               s1_d.cls = CLS_NORMAL;
    end

    fp_round_rne #(.W(MAN_W)) u_round (
        .man     (s1_q.man),
        .guard   (s1_q.guard),
        .sticky  (s1_q.sticky),
        .man_rnd (man_rnd),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    // S2: apply rounding; a mantissa carry-out bumps the exponent (mantissa wraps to 0).
    always_comb begin
        s2_d         = '0;
        s2_d.s       = s1_q.s;
        s2_d.e       = s1_q.e + ES_W'(rnd_carry);
        s2_d.man     = man_rnd;
        s2_d.inexact = rnd_inexact;
        s2_d.cls     = s1_q.cls;
    end

    assign e3 = s2_q.e;

    // S3: exception overrides, then exponent range, then pack.
    always_comb begin
        res_d = '0;
        flg_d = '0;
        case (s2_q.cls)
            CLS_INVALID: begin
                res_d              = QNAN;
                flg_d[FLG_INVALID] = 1'b1;
            end
            CLS_NAN:  res_d = QNAN;
            CLS_INF:  res_d = {s2_q.s, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: res_d = {s2_q.s, {(DWIDTH-1){1'b0}}};
            default: begin
                if (e3 >= E_MAX) begin
                    res_d               = {s2_q.s, EXP_ONES, {MAN_W{1'b0}}};
                    flg_d[FLG_OVERFLOW] = 1'b1;
                    flg_d[FLG_INEXACT]  = 1'b1;
                end else if (e3 <= E_ZERO) begin
                    res_d                = {s2_q.s, {(DWIDTH-1){1'b0}}};
                    flg_d[FLG_UNDERFLOW] = 1'b1;
                    flg_d[FLG_INEXACT]   = 1'b1;
                end else begin
                    res_d              = {s2_q.s, e3[EXP_W-1:0], s2_q.man};
                    flg_d[FLG_INEXACT] = s2_q.inexact;
                end
            end
        endcase
    end

    // Stage valids and the output register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (load1) v1 <= in_valid;
            if (load2) v2 <= v1;
            if (load3) v3 <= v2;
            if (load3 && v2) begin
                result <= res_d;
                flags  <= flg_d;
            end
        end
    end

    // Intermediate payload registers, loaded only alongside a valid entry.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; the valid bits alone decide whether it matters.
        if (load1 && in_valid) s1_q <= s1_d;
        if (load2 && v1)       s2_q <= s2_d;
    end

endmodule

// File: tb/tb_fp_mult_assemble.sv
// Scoreboard bench for fp_mult_assemble: directed vectors, decoupled monitor.
module tb_fp_mult_assemble;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        Sa, Sb;
    logic [4:0]  Ea, Eb;
    logic [21:0] Mp;
    logic [4:0]  InputExc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   n_out  = 0;
    bit   mon_en = 1'b1;
    bit   saw_stall;

    always #5 clk = ~clk;

    fp_mult_assemble dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sa        (Sa),
        .Sb        (Sb),
        .Ea        (Ea),
        .Eb        (Eb),
        .Mp        (Mp),
        .InputExc  (InputExc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: compare the presented output with the oldest expectation every cycle
    // (so stalled outputs must stay put); pop only when the consumer takes it.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check({sb_q[0].name, "_result"}, 32'(result), 32'(sb_q[0].res));
                check({sb_q[0].name, "_flags"},  32'(flags),  32'(sb_q[0].flg));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // Drive one input (called at posedge+1), wait for acceptance, optionally record expectation.
    task automatic send(input string name, input bit expect_it,
                        input logic sa, input logic sb, input logic [4:0] ea, input logic [4:0] eb,
                        input logic [21:0] mp, input logic [4:0] exc,
                        input logic [15:0] res, input logic [3:0] flg);
        bit ok = 1'b0;
        int waited = 0;
        exp_t e;
        Sa = sa; Sb = sb; Ea = ea; Eb = eb; Mp = mp; InputExc = exc;
        in_valid = 1'b1;
        while (!ok && waited <= 50) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) saw_stall = 1'b1;
            @(posedge clk);
            waited++;
        end
        if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        else if (expect_it) begin
            e.name = name; e.res = res; e.flg = flg;
            sb_q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check(name, 32'(lat), 32'd3);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Sa = 1'b0; Sb = 1'b0; Ea = '0; Eb = '0; Mp = '0; InputExc = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    32'(result),    32'd0);
        check("reset_flags",     32'(flags),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // First transaction and its latency
        send("mul_1p5x2", 1, 0, 0, 5'h0F, 5'h10, 22'h180000, 5'b00000, 16'h4200, 4'b0000);
        check_latency("latency_first");
        idle(3);

        // Directed vectors, back to back with the consumer always ready
        send("neg_1p5x2",   1, 1, 0, 5'h0F, 5'h10, 22'h180000, 5'b00000, 16'hC200, 4'b0000);
        send("mul_1p5x1p5", 1, 0, 0, 5'h0F, 5'h0F, 22'h240000, 5'b00000, 16'h4080, 4'b0000);
        send("overflow",    1, 0, 0, 5'h1E, 5'h1E, 22'h100000, 5'b00000, 16'h7C00, 4'b0101);
        send("underflow",   1, 0, 0, 5'h01, 5'h01, 22'h100000, 5'b00000, 16'h0000, 4'b0011);
        send("exp_zero",    1, 0, 0, 5'h07, 5'h08, 22'h100000, 5'b00000, 16'h0000, 4'b0011);
        send("exp_one",     1, 0, 0, 5'h08, 5'h08, 22'h100000, 5'b00000, 16'h0400, 4'b0000);
        send("inf_x_zero",  1, 0, 0, 5'h1F, 5'h00, 22'h100000, 5'b10010, 16'h7E00, 4'b1000);
        send("nan_a",       1, 0, 0, 5'h1F, 5'h0F, 22'h100000, 5'b11000, 16'h7E00, 4'b0000);
        send("inf_b_neg",   1, 1, 0, 5'h0F, 5'h1F, 22'h100000, 5'b10001, 16'hFC00, 4'b0000);
        send("zero_a_neg",  1, 1, 0, 5'h00, 5'h0F, 22'h100000, 5'b00000, 16'h8000, 4'b0000);
        send("rne_tie_even",1, 0, 0, 5'h0F, 5'h0F, 22'h100200, 5'b00000, 16'h3C00, 4'b0001);
        send("rne_tie_odd", 1, 0, 0, 5'h0F, 5'h0F, 22'h100600, 5'b00000, 16'h3C02, 4'b0001);
        send("rne_sticky",  1, 0, 0, 5'h0F, 5'h0F, 22'h100201, 5'b00000, 16'h3C01, 4'b0001);
        send("rne_carry",   1, 0, 0, 5'h0F, 5'h0F, 22'h1FFE00, 5'b00000, 16'h4000, 4'b0001);
        send("rne_to_inf",  1, 0, 0, 5'h0F, 5'h1E, 22'h1FFE00, 5'b00000, 16'h7C00, 4'b0101);
        drain("drain_directed");

        // Backpressure: consumer stalls for 7 cycles while 6 inputs stream in
        saw_stall  = 1'b0;
        out_before = n_out;
        fork
            begin
                repeat (2) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (7) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 6; i++) begin
            logic [4:0] eb_i;
            logic [4:0] ex_i;
            eb_i = 5'(16 + i);
            ex_i = 5'(16 + i);
            send($sformatf("bp%0d", i), 1, 0, 0, 5'h0F, eb_i, 22'h180000, 5'b00000,
                 {1'b0, ex_i, 10'h200}, 4'b0000);
        end
        drain("drain_backpressure");
        check("bp_in_ready_fell", 32'(saw_stall), 32'd1);
        check("bp_count", 32'(n_out - out_before), 32'd6);

        // Reset with three entries in flight
        mon_en    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send("flushed", 0, 0, 0, 5'h0F, 5'h10, 22'h180000, 5'b00000, 16'h0000, 4'b0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready",  32'(in_ready),  32'd1);
        check("midreset_result",    32'(result),    32'd0);
        @(posedge clk); #1;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        send("after_reset", 1, 0, 1, 5'h0F, 5'h10, 22'h180000, 5'b00000, 16'hC200, 4'b0000);
        check_latency("latency_after_reset");
        drain("drain_final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
